mem_arbiter: RTL and testbench

- Two-master arbiter for the single off-chip data memory port.
- Master 0 is the instruction cache refill port; master 1 is the dcache controller.
- Grants one 256-bit line transaction at a time and holds the grant until memory acknowledges.
- Steers ack and read data back to the granted master. Sits between the CPU's cache controllers and Data_Memory.

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of the single off-chip line memory.
// Master 0 is the icache refill port and master 1 is the dcache controller.
// One line transaction is granted at a time, and the grant is held until memory acks.
// Optional macro ARB_RR_EN: round-robin tie-break between the two masters.
// When the macro is undefined, the dcache always wins a tie.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    REL  = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              m1_wins_c;
  logic              take0_c;
  logic              take1_c;
  logic              ack_cycle_c;
  logic [DATA_W-1:0] m0_data_q;
  logic [DATA_W-1:0] m1_data_q;

`ifdef ARB_RR_EN
  logic last_grant_q;

  // On a tie, the master that was not served last wins.
  always_comb begin
    m1_wins_c = m1_enable_i & (~m0_enable_i | ~last_grant_q);
  end

  // Remember which master was granted most recently.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_grant_q <= 1'b0;
    end else if (take1_c) begin
      last_grant_q <= 1'b1;
    end else if (take0_c) begin
      last_grant_q <= 1'b0;
    end
  end
`else
  // Fixed priority: a dcache miss stalls the pipeline, so the dcache goes first.
  always_comb begin
    m1_wins_c = m1_enable_i;
  end
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    take0_c = 1'b0;
    take1_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (m1_wins_c) begin
          state_d = GNT1;
          take1_c = 1'b1;
        end else if (m0_enable_i) begin
          state_d = GNT0;
          take0_c = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (mem_ack_i) begin
          state_d = REL;
        end
      end
      REL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // An ack only means anything while a grant is outstanding.
  always_comb begin
    ack_cycle_c = mem_ack_i & ((state_q == GNT0) | (state_q == GNT1));
  end

  // Memory-side request registers: captured on grant, frozen until ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else if (take1_c) begin
      mem_enable_o <= 1'b1;
      mem_write_o  <= m1_write_i;
      mem_addr_o   <= m1_addr_i;
      mem_data_o   <= m1_data_i;
    end else if (take0_c) begin
      mem_enable_o <= 1'b1;
      mem_write_o  <= m0_write_i;
      mem_addr_o   <= m0_addr_i;
      mem_data_o   <= m0_data_i;
    end else if (ack_cycle_c) begin
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
    end
  end

  // Per-master read data. It updates even if the master has already dropped its request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m0_data_q <= '0;
      m1_data_q <= '0;
    end else if (ack_cycle_c) begin
      if (state_q == GNT0) begin
        m0_data_q <= mem_data_i;
      end else begin
        m1_data_q <= mem_data_i;
      end
    end
  end

  // Ack steering and read-data bypass. A master that has dropped its request gets no ack.
  always_comb begin
    m0_ack_o  = ack_cycle_c & (state_q == GNT0) & m0_enable_i;
    m1_ack_o  = ack_cycle_c & (state_q == GNT1) & m1_enable_i;
    m0_data_o = (ack_cycle_c && (state_q == GNT0)) ? mem_data_i : m0_data_q;
    m1_data_o = (ack_cycle_c && (state_q == GNT1)) ? mem_data_i : m1_data_q;
    grant_o   = {state_q == GNT1, state_q == GNT0};
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized run.
// The randomized run is checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 256;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
  logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
  logic [DATA_W-1:0] m0_data_i, m1_data_i;
  logic              m0_ack_o, m1_ack_o;
  logic [DATA_W-1:0] m0_data_o, m1_data_o;
  logic              mem_enable_o, mem_write_o, mem_ack_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o, mem_data_i;
  logic [1:0]        grant_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_d0, exp_d1;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
    .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs are driven and outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk_i);
  endtask

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic test_reset();
    rst_i = 1'b0;
    m0_enable_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = '0; m0_data_i = '0;
    m1_enable_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = '0; m1_data_i = '0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    exp_d0 = '0; exp_d1 = '0;
    repeat (3) tick();
    n_checks++; if ({mem_enable_o, mem_write_o, mem_addr_o} !== '0) begin n_fail++; $display("FAIL rst_mem_ctl: got %0b %0b %h want 0 0 0", mem_enable_o, mem_write_o, mem_addr_o); end
    n_checks++; if (mem_data_o !== '0) begin n_fail++; $display("FAIL rst_mem_data: got %h want 0", mem_data_o); end
    n_checks++; if ({grant_o, m0_ack_o, m1_ack_o} !== 4'b0) begin n_fail++; $display("FAIL rst_grant_ack: got %b want 0000", {grant_o, m0_ack_o, m1_ack_o}); end
    n_checks++; if ((m0_data_o | m1_data_o) !== '0) begin n_fail++; $display("FAIL rst_data_o: got %h %h want 0", m0_data_o, m1_data_o); end
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    m0_enable_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h0000_0400; m0_data_i = rand_line();
    #1;
    n_checks++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL sr_en_early: got %b want 0", mem_enable_o); end
    tick();
    n_checks++; if (mem_enable_o !== 1'b1) begin n_fail++; $display("FAIL sr_en_rise: got %b want 1", mem_enable_o); end
    n_checks++; if (mem_addr_o !== 32'h400 || mem_write_o !== 1'b0) begin n_fail++; $display("FAIL sr_addr: got %h w%b want 400 w0", mem_addr_o, mem_write_o); end
    for (int i = 0; i < 9; i++) begin
      tick();
      n_checks++; if (grant_o !== 2'b01 || mem_enable_o !== 1'b1 || m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL sr_hold: cyc %0d got g%b e%b a%b want g01 e1 a0", i, grant_o, mem_enable_o, m0_ack_o); end
    end
    mem_ack_i = 1'b1; mem_data_i = {32{8'hA5}};
    #1;
    n_checks++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL sr_ack: got m0 %b m1 %b want 1 0", m0_ack_o, m1_ack_o); end
    n_checks++; if (m0_data_o !== {32{8'hA5}}) begin n_fail++; $display("FAIL sr_data_bypass: got %h want a5..", m0_data_o); end
    tick();
    mem_ack_i = 1'b0; mem_data_i = '0; m0_enable_i = 1'b0;
    exp_d0 = {32{8'hA5}};
    #1;
    n_checks++; if (m0_ack_o !== 1'b0 || mem_enable_o !== 1'b0 || grant_o !== 2'b00) begin n_fail++; $display("FAIL sr_rel: got a%b e%b g%b want a0 e0 g00", m0_ack_o, mem_enable_o, grant_o); end
    n_checks++; if (m0_data_o !== exp_d0) begin n_fail++; $display("FAIL sr_data_reg: got %h want %h", m0_data_o, exp_d0); end
    tick();
  endtask

  // Tie, frozen inputs while granted, and the 3-cycle turnaround.
  task automatic test_contention();
    logic [DATA_W-1:0] w1, r1, r0;
    w1 = {16{16'h1234}}; r1 = rand_line(); r0 = rand_line();
    m0_enable_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h100;
    m1_enable_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h800; m1_data_i = w1;
    tick();
    n_checks++; if (grant_o !== 2'b10 || mem_write_o !== 1'b1 || mem_addr_o !== 32'h800) begin n_fail++; $display("FAIL ct_first: got g%b w%b %h want g10 w1 800", grant_o, mem_write_o, mem_addr_o); end
    n_checks++; if (mem_data_o !== w1) begin n_fail++; $display("FAIL ct_wdata: got %h want %h", mem_data_o, w1); end
    m1_addr_i = 32'hC00; m1_data_i = '0; m1_write_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (mem_addr_o !== 32'h800 || mem_write_o !== 1'b1 || mem_data_o !== w1) begin n_fail++; $display("FAIL frozen: cyc %0d got %h w%b want 800 w1", i, mem_addr_o, mem_write_o); end
    end
    mem_ack_i = 1'b1; mem_data_i = r1;
    #1;
    n_checks++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL ct_ack1: got m0 %b m1 %b want 0 1", m0_ack_o, m1_ack_o); end
    tick();
    mem_ack_i = 1'b0; m1_enable_i = 1'b0; exp_d1 = r1;
    #1;
    n_checks++; if (grant_o !== 2'b00 || mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL ct_rel: got g%b e%b want g00 e0", grant_o, mem_enable_o); end
    tick();
    n_checks++; if (grant_o !== 2'b00 || mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL ct_idle: got g%b e%b want g00 e0", grant_o, mem_enable_o); end
    tick();
    n_checks++; if (grant_o !== 2'b01 || mem_enable_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_write_o !== 1'b0) begin n_fail++; $display("FAIL ct_second: got g%b e%b %h w%b want g01 e1 100 w0", grant_o, mem_enable_o, mem_addr_o, mem_write_o); end
    mem_ack_i = 1'b1; mem_data_i = r0;
    #1;
    n_checks++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || m1_data_o !== exp_d1) begin n_fail++; $display("FAIL ct_ack0: got m0 %b m1 %b want 1 0", m0_ack_o, m1_ack_o); end
    tick();
    mem_ack_i = 1'b0; m0_enable_i = 1'b0; exp_d0 = r0;
    tick();
  endtask

  task automatic test_early_drop();
    logic [DATA_W-1:0] r;
    r = rand_line();
    m0_enable_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h200;
    tick();
    repeat (3) tick();
    m0_enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (mem_enable_o !== 1'b1 || grant_o !== 2'b01) begin n_fail++; $display("FAIL ed_hold: cyc %0d got e%b g%b want e1 g01", i, mem_enable_o, grant_o); end
    end
    mem_ack_i = 1'b1; mem_data_i = r;
    #1;
    n_checks++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL ed_no_ack: got m0 %b m1 %b want 0 0", m0_ack_o, m1_ack_o); end
    tick();
    mem_ack_i = 1'b0; exp_d0 = r;
    #1;
    n_checks++; if (m0_data_o !== exp_d0 || mem_enable_o !== 1'b0 || grant_o !== 2'b00) begin n_fail++; $display("FAIL ed_rel: got %h e%b g%b want %h e0 g00", m0_data_o, mem_enable_o, grant_o, exp_d0); end
    tick();
  endtask

  task automatic test_stray_ack();
    mem_ack_i = 1'b1; mem_data_i = rand_line();
    #1;
    n_checks++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL st_ack: got m0 %b m1 %b want 0 0", m0_ack_o, m1_ack_o); end
    tick();
    mem_ack_i = 1'b0;
    #1;
    n_checks++; if (m0_data_o !== exp_d0 || m1_data_o !== exp_d1) begin n_fail++; $display("FAIL st_data: got %h %h want %h %h", m0_data_o, m1_data_o, exp_d0, exp_d1); end
    n_checks++; if (grant_o !== 2'b00 || mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL st_state: got g%b e%b want g00 e0", grant_o, mem_enable_o); end
    m1_enable_i = 1'b1; m1_write_i = 1'b0; m1_addr_i = 32'h40;
    tick();
    n_checks++; if (grant_o !== 2'b10 || mem_enable_o !== 1'b1) begin n_fail++; $display("FAIL st_still_idle: got g%b e%b want g10 e1", grant_o, mem_enable_o); end
  endtask

  // Runs while master 1 is still granted from the stray-ack test.
  task automatic test_async_reset();
    #2 rst_i = 1'b0;
    #1;
    n_checks++; if ({mem_enable_o, mem_write_o, grant_o, m0_ack_o, m1_ack_o} !== 6'b0 || mem_addr_o !== '0) begin n_fail++; $display("FAIL ar_ctl: got e%b g%b %h want e0 g00 0", mem_enable_o, grant_o, mem_addr_o); end
    n_checks++; if ((m0_data_o | m1_data_o | mem_data_o) !== '0) begin n_fail++; $display("FAIL ar_data: got %h %h want 0", m0_data_o, m1_data_o); end
    m1_enable_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b1;
    exp_d0 = '0; exp_d1 = '0;
    tick();
    mem_ack_i = 1'b1; mem_data_i = rand_line();
    #1;
    n_checks++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin n_fail++; $display("FAIL ar_late_ack: got m0 %b m1 %b want 0 0", m0_ack_o, m1_ack_o); end
    tick();
    mem_ack_i = 1'b0;
    #1;
    n_checks++; if (grant_o !== 2'b00 || m1_data_o !== '0 || m0_data_o !== '0) begin n_fail++; $display("FAIL ar_after: got g%b %h want g00 0", grant_o, m1_data_o); end
  endtask

  // Random request patterns; the model derives the service order from the arbitration rule.
  task automatic test_random();
    logic [1:0]        pend;
    logic              wr [2];
    logic [ADDR_W-1:0] ad [2];
    logic [DATA_W-1:0] wd [2];
    logic [DATA_W-1:0] rd;
    logic              last_m;
    int                who;
    last_m = 1'b0;
    for (int r = 0; r < 40; r++) begin
      pend = 2'($urandom_range(1, 3));
      for (int m = 0; m < 2; m++) begin
        wr[m] = 1'($urandom); ad[m] = $urandom; wd[m] = rand_line();
      end
      m0_enable_i = pend[0]; m0_write_i = wr[0]; m0_addr_i = ad[0]; m0_data_i = wd[0];
      m1_enable_i = pend[1]; m1_write_i = wr[1]; m1_addr_i = ad[1]; m1_data_i = wd[1];
      while (pend != 2'b00) begin
`ifdef ARB_RR_EN
        who = (pend == 2'b11) ? (last_m ? 0 : 1) : (pend[1] ? 1 : 0);
`else
        who = pend[1] ? 1 : 0;
`endif
        for (int k = 0; k < 6 && grant_o == 2'b00; k++) tick();
        n_checks++; if (grant_o !== (who == 1 ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rnd_grant: round %0d got %b want master %0d", r, grant_o, who); end
        n_checks++; if (mem_addr_o !== ad[who] || mem_write_o !== wr[who] || mem_data_o !== wd[who] || mem_enable_o !== 1'b1) begin n_fail++; $display("FAIL rnd_req: round %0d got %h w%b e%b want %h w%b e1", r, mem_addr_o, mem_write_o, mem_enable_o, ad[who], wr[who]); end
        last_m = (who == 1);
        if (who == 1) begin m1_addr_i = $urandom; m1_write_i = ~wr[1]; end
        else          begin m0_addr_i = $urandom; m0_write_i = ~wr[0]; end
        repeat ($urandom_range(0, 4)) tick();
        rd = rand_line();
        mem_ack_i = 1'b1; mem_data_i = rd;
        #1;
        n_checks++; if (m0_ack_o !== (who == 0) || m1_ack_o !== (who == 1)) begin n_fail++; $display("FAIL rnd_ack: round %0d got m0 %b m1 %b want master %0d", r, m0_ack_o, m1_ack_o, who); end
        n_checks++; if (mem_addr_o !== ad[who]) begin n_fail++; $display("FAIL rnd_frozen: round %0d got %h want %h", r, mem_addr_o, ad[who]); end
        tick();
        mem_ack_i = 1'b0;
        if (who == 1) begin exp_d1 = rd; m1_enable_i = 1'b0; end
        else          begin exp_d0 = rd; m0_enable_i = 1'b0; end
        pend[who] = 1'b0;
        #1;
        n_checks++; if (m0_data_o !== exp_d0 || m1_data_o !== exp_d1) begin n_fail++; $display("FAIL rnd_data: round %0d got %h %h want %h %h", r, m0_data_o, m1_data_o, exp_d0, exp_d1); end
        n_checks++; if (mem_enable_o !== 1'b0 || grant_o !== 2'b00) begin n_fail++; $display("FAIL rnd_rel: round %0d got e%b g%b want e0 g00", r, mem_enable_o, grant_o); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_early_drop();
    test_stray_ack();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
